// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-write sequencer.
//   state_t  : sequencer states
//   SEL_*    : byte_sel encodings for the three bytes of a write
//   ENTRY_W  : width of one write-table entry ({reg, data})
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BYTE,
    ACK,
    STOP,
    GAP
  } state_t;

  localparam logic [1:0] SEL_ADDR = 2'd0;
  localparam logic [1:0] SEL_REG  = 2'd1;
  localparam logic [1:0] SEL_DATA = 2'd2;

  localparam int ENTRY_W = 16;

endpackage

// File: rtl/i2c_seq_writer_tick_gen.sv
// Quarter-period timebase for the I2C sequencer.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   en   in  1 = run; 0 = hold divider and phase at 0
//   tick out one-cycle pulse when the divider wraps (end of a quarter)
//   q    out current quarter-phase 0..3 of the SCL bit period
module i2c_tick_gen #(
  parameter int CLK_DIV = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       tick,
  output logic [1:0] q
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic [1:0]       q_reg;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_reg <= '0;
      q_reg   <= 2'd0;
    end else if (div_reg == DIV_LAST) begin
      div_reg <= '0;
      q_reg   <= q_reg + 2'd1;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  assign tick = en && (div_reg == DIV_LAST);
  assign q    = q_reg;

endmodule

// File: rtl/i2c_seq_writer.sv
// I2C write sequencer: on start, sends NUM_WRITES three-byte writes
// (slave address + W, register, data) from a table latched at start,
// checks every ACK, retries NACKed writes, and waits GAP_CYCLES between
// writes. SCL is produced from a quarter-period tick, no derived clock.
//   s_clk_25mhz in  system clock
//   rst         in  synchronous active-high reset
//   start       in  one-cycle pulse, accepted only when idle
//   wr_table    in  entry k = [16k+15:16k] = {reg, data}, entry 0 first
//   sda_in      in  synchronised SDA pad level
//   scl_oe      out 1 = pull SCL low
//   sda_oe      out 1 = pull SDA low
//   busy        out sequence in progress
//   done        out one-cycle pulse on success
//   nack_err    out one-cycle pulse on abort after retries
//   fail_idx    out failing entry, held until the next start
module i2c_seq_writer
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV    = 5,
  parameter logic [6:0] SLAVE_ADDR = 7'h74,
  parameter int         NUM_WRITES = 4,
  parameter int         GAP_CYCLES = 50000,
  parameter int         MAX_RETRY  = 2
) (
  input  logic                          s_clk_25mhz,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_WRITES*ENTRY_W-1:0] wr_table,
  input  logic                          sda_in,
  output logic                          scl_oe,
  output logic                          sda_oe,
  output logic                          busy,
  output logic                          done,
  output logic                          nack_err,
  output logic [3:0]                    fail_idx
);

  localparam int TBL_W  = NUM_WRITES * ENTRY_W;
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int RTRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int IDX_W  = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;

  localparam logic [GAP_W-1:0]  GAP_LAST   = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [RTRY_W-1:0] RETRY_MAX  = RTRY_W'(MAX_RETRY);
  localparam logic [3:0]        LAST_ENTRY = 4'(NUM_WRITES - 1);
  localparam logic [7:0]        ADDR_BYTE  = {SLAVE_ADDR, 1'b0};

  state_t              state_reg, state_next;
  logic [TBL_W-1:0]    table_reg, table_next;
  logic [3:0]          entry_reg, entry_next;
  logic [RTRY_W-1:0]   retry_reg, retry_next;
  logic                nack_reg, nack_next;
  logic                ack_bit_reg, ack_bit_next;
  logic [1:0]          byte_sel_reg, byte_sel_next;
  logic [2:0]          bit_cnt_reg, bit_cnt_next;
  logic [7:0]          shift_reg, shift_next;
  logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
  logic                done_reg, done_next;
  logic                nack_err_reg, nack_err_next;
  logic [3:0]          fail_idx_reg, fail_idx_next;
  logic                scl_oe_reg, scl_oe_next;
  logic                sda_oe_reg, sda_oe_next;

  logic                tick;
  logic [1:0]          q;
  logic                tick_en;
  logic                last_q;
  logic                gap_exit;
  logic [1:0]          sel_inc;
  logic [ENTRY_W-1:0]  cur_entry;

  // Table entries padded to a power of two so the entry index always
  // selects a defined slot.
  logic [ENTRY_W-1:0]  entries [2**IDX_W];

  generate
    for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_entry
      if (gi < NUM_WRITES) begin : g_used
        assign entries[gi] = table_reg[gi*ENTRY_W +: ENTRY_W];
      end else begin : g_pad
        assign entries[gi] = '0;
      end
    end
  endgenerate

  assign cur_entry = entries[entry_reg[IDX_W-1:0]];

  function automatic logic [7:0] pick_byte(input logic [1:0] sel,
                                           input logic [ENTRY_W-1:0] ent);
    case (sel)
      SEL_ADDR: pick_byte = ADDR_BYTE;
      SEL_REG:  pick_byte = ent[15:8];
      default:  pick_byte = ent[7:0];
    endcase
  endfunction

  // The bit timebase only runs while bus activity is being generated; it is
  // held in GAP so each START begins at a fresh quarter boundary.
  assign tick_en = (state_reg != IDLE) && (state_reg != GAP);

  i2c_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (s_clk_25mhz),
    .rst  (rst),
    .en   (tick_en),
    .tick (tick),
    .q    (q)
  );

  assign last_q  = tick && (q == 2'd3);
  assign sel_inc = byte_sel_reg + 2'd1;

  always_ff @(posedge s_clk_25mhz) begin
    if (rst) begin
      state_reg    <= IDLE;
      table_reg    <= '0;
      entry_reg    <= '0;
      retry_reg    <= '0;
      nack_reg     <= 1'b0;
      ack_bit_reg  <= 1'b0;
      byte_sel_reg <= SEL_ADDR;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      gap_cnt_reg  <= '0;
      done_reg     <= 1'b0;
      nack_err_reg <= 1'b0;
      fail_idx_reg <= '0;
      scl_oe_reg   <= 1'b0;
      sda_oe_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      table_reg    <= table_next;
      entry_reg    <= entry_next;
      retry_reg    <= retry_next;
      nack_reg     <= nack_next;
      ack_bit_reg  <= ack_bit_next;
      byte_sel_reg <= byte_sel_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      gap_cnt_reg  <= gap_cnt_next;
      done_reg     <= done_next;
      nack_err_reg <= nack_err_next;
      fail_idx_reg <= fail_idx_next;
      scl_oe_reg   <= scl_oe_next;
      sda_oe_reg   <= sda_oe_next;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    state_next    = state_reg;
    table_next    = table_reg;
    entry_next    = entry_reg;
    retry_next    = retry_reg;
    nack_next     = nack_reg;
    ack_bit_next  = ack_bit_reg;
    byte_sel_next = byte_sel_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    gap_cnt_next  = gap_cnt_reg;
    done_next     = 1'b0;
    nack_err_next = 1'b0;
    fail_idx_next = fail_idx_reg;
    gap_exit      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = START;
          table_next    = wr_table;
          entry_next    = '0;
          retry_next    = '0;
          nack_next     = 1'b0;
          fail_idx_next = '0;
          byte_sel_next = SEL_ADDR;
          bit_cnt_next  = '0;
          gap_cnt_next  = '0;
        end
      end

      START: begin
        if (last_q) begin
          state_next    = BYTE;
          byte_sel_next = SEL_ADDR;
          bit_cnt_next  = '0;
          shift_next    = ADDR_BYTE;
        end
      end

      BYTE: begin
        if (last_q) begin
          if (bit_cnt_reg == 3'd7) begin
            state_next = ACK;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            shift_next   = {shift_reg[6:0], 1'b0};
          end
        end
      end

      ACK: begin
        // Sample in the middle of the SCL-high window.
        if (tick && (q == 2'd2)) begin
          ack_bit_next = sda_in;
        end
        if (last_q) begin
          if (ack_bit_reg) begin
            state_next = STOP;
            nack_next  = 1'b1;
          end else if (byte_sel_reg != SEL_DATA) begin
            state_next    = BYTE;
            byte_sel_next = sel_inc;
            bit_cnt_next  = '0;
            shift_next    = pick_byte(sel_inc, cur_entry);
          end else begin
            state_next = STOP;
          end
        end
      end

      STOP: begin
        if (last_q) begin
          if (GAP_CYCLES == 0) begin
            gap_exit = 1'b1;
          end else begin
            state_next   = GAP;
            gap_cnt_next = '0;
          end
        end
      end

      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          gap_exit = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // End of the inter-transaction gap: advance, retry or finish.
    if (gap_exit) begin
      gap_cnt_next = '0;
      if (!nack_reg) begin
        retry_next = '0;
        if (entry_reg == LAST_ENTRY) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          entry_next = entry_reg + 4'd1;
          state_next = START;
        end
      end else if (retry_reg != RETRY_MAX) begin
        retry_next = retry_reg + 1'b1;
        nack_next  = 1'b0;
        state_next = START;
      end else begin
        state_next    = IDLE;
        nack_err_next = 1'b1;
        fail_idx_next = entry_reg;
        nack_next     = 1'b0;
        retry_next    = '0;
      end
    end
  end

  // Pad enables decoded from state and quarter; registered so the pads
  // see glitch-free levels (both lines share the same one-cycle delay).
  always_comb begin
    scl_oe_next = 1'b0;
    sda_oe_next = 1'b0;
    case (state_reg)
      START: begin
        sda_oe_next = (q >= 2'd2);
        scl_oe_next = (q == 2'd3);
      end
      BYTE: begin
        scl_oe_next = (q < 2'd2);
        sda_oe_next = ~shift_reg[7];
      end
      ACK: begin
        scl_oe_next = (q < 2'd2);
      end
      STOP: begin
        scl_oe_next = (q == 2'd0);
        sda_oe_next = (q < 2'd2);
      end
      default: begin
        scl_oe_next = 1'b0;
        sda_oe_next = 1'b0;
      end
    endcase
  end

  assign scl_oe   = scl_oe_reg;
  assign sda_oe   = sda_oe_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign nack_err = nack_err_reg;
  assign fail_idx = fail_idx_reg;

endmodule

// File: tb/tb_i2c_seq_writer.sv
// Scoreboard bench for i2c_seq_writer: a reference model expands each
// table + slave NACK plan into the expected byte stream and outcome; a bus
// monitor (also acting as the slave) decodes the open-drain lines and
// compares against the queues.
module tb_i2c_seq_writer;

  localparam int         CLK_DIV = 5;
  localparam int         NUM     = 4;
  localparam int         GAP     = 40;
  localparam int         MAXR    = 2;
  localparam logic [6:0] SADDR   = 7'h74;
  localparam int         TW      = NUM * 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [TW-1:0] wr_table = '0;
  logic          sda_in;
  logic          scl_oe, sda_oe, busy, done, nack_err;
  logic [3:0]    fail_idx;
  logic          slave_pull = 1'b0;

  assign sda_in = ~(sda_oe | slave_pull);

  always #20 clk = ~clk;

  i2c_seq_writer #(
    .CLK_DIV    (CLK_DIV),
    .SLAVE_ADDR (SADDR),
    .NUM_WRITES (NUM),
    .GAP_CYCLES (GAP),
    .MAX_RETRY  (MAXR)
  ) dut (
    .s_clk_25mhz (clk),
    .rst         (rst),
    .start       (start),
    .wr_table    (wr_table),
    .sda_in      (sda_in),
    .scl_oe      (scl_oe),
    .sda_oe      (sda_oe),
    .busy        (busy),
    .done        (done),
    .nack_err    (nack_err),
    .fail_idx    (fail_idx)
  );

  typedef struct {
    bit ok;
    int idx;
  } out_t;

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] exp_bytes [$];
  out_t       exp_out [$];
  int         nack_plan [16];   // per transaction: byte index NACKed, 3 = none
  int         seq_id = 0;
  int         outcomes_seen = 0;

  function automatic void chk(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
    end
  endfunction

  // Reference model: walk entries with the retry rule and list bytes sent.
  task automatic build_expect(input logic [TW-1:0] tbl, output int ntx);
    int entry = 0;
    int retry = 0;
    int t = 0;
    int n;
    logic [7:0] b [3];
    out_t o;
    while (t < 16) begin
      b[0] = {SADDR, 1'b0};
      b[1] = tbl[entry*16+8 +: 8];
      b[2] = tbl[entry*16 +: 8];
      n = nack_plan[t];
      for (int k = 0; k < 3; k++) begin
        exp_bytes.push_back(b[k]);
        if (n == k) break;
      end
      t++;
      if (n < 3) begin
        if (retry < MAXR) begin
          retry++;
        end else begin
          o.ok = 1'b0; o.idx = entry;
          exp_out.push_back(o);
          break;
        end
      end else begin
        retry = 0;
        entry++;
        if (entry == NUM) begin
          o.ok = 1'b1; o.idx = 0;
          exp_out.push_back(o);
          break;
        end
      end
    end
    ntx = t;
  endtask

  // Bus monitor / slave state.
  logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_done = 1'b0;
  logic       in_txn = 1'b0, in_bits = 1'b0, last_fall_bit = 1'b0, pend_valid = 1'b0;
  int         bitcnt = 0, byte_idx = 0, txn_cnt = 0, mon_seq = 0;
  int         cyc = 0, last_stop_cyc = 0, run_len = 0, level_len = 0, pend_low = 0;
  logic       stop_valid = 1'b0;
  logic [7:0] shreg = '0;
  logic [7:0] got [3];

  always @(negedge clk) begin
    logic scl_l, sda_l;
    logic [7:0] e;
    out_t o;
    scl_l = ~scl_oe;
    sda_l = ~(sda_oe | slave_pull);
    cyc++;
    if (rst) begin
      in_txn = 0; in_bits = 0; bitcnt = 0; byte_idx = 0; slave_pull = 0;
      pend_valid = 0; last_fall_bit = 0; stop_valid = 0; run_len = 0;
      exp_bytes.delete();
      exp_out.delete();
    end else begin
      if (mon_seq != seq_id) begin
        mon_seq = seq_id; txn_cnt = 0; stop_valid = 0;
      end
      if (scl_l != prev_scl) begin
        level_len = run_len; run_len = 1;
      end else begin
        run_len++;
      end

      if (scl_l && prev_scl && (sda_l != prev_sda)) begin
        if (!sda_l) begin
          chk("start_outside_txn", in_txn, 0);
          if (stop_valid) chk("gap_ge_min", int'((cyc - last_stop_cyc) >= GAP), 1);
          in_txn = 1; in_bits = 0; bitcnt = 0; byte_idx = 0;
          last_fall_bit = 0; pend_valid = 0;
          txn_cnt++;
        end else begin
          chk("stop_on_byte_boundary", int'(in_txn && bitcnt == 0), 1);
          if (in_txn)
            $display("txn seq=%0d #%0d: %0d byte(s) %02h %02h %02h", seq_id, txn_cnt,
                     byte_idx, got[0], got[1], got[2]);
          in_txn = 0; stop_valid = 1; last_stop_cyc = cyc; slave_pull = 0;
        end
      end else if (!prev_scl && scl_l && in_txn) begin
        pend_low = level_len;
        pend_valid = last_fall_bit;
      end else if (prev_scl && !scl_l && in_txn) begin
        if (!in_bits) begin
          in_bits = 1;            // SCL falling that completes START
        end else begin
          chk("scl_high_len", level_len, 2 * CLK_DIV);
          if (pend_valid) chk("scl_low_len", pend_low, 2 * CLK_DIV);
          last_fall_bit = 1;
          if (bitcnt < 8) begin
            shreg = {shreg[6:0], prev_sda};
            bitcnt++;
            if (bitcnt == 8)
              slave_pull = (txn_cnt >= 1 && nack_plan[(txn_cnt-1) % 16] != byte_idx);
          end else begin
            if (byte_idx < 3) got[byte_idx] = shreg;
            if (exp_bytes.size() == 0) begin
              chk("unexpected_byte", shreg, -1);
            end else begin
              e = exp_bytes.pop_front();
              chk("bus_byte", shreg, e);
            end
            bitcnt = 0; byte_idx++; slave_pull = 0;
          end
        end
      end

      if (done || nack_err) begin
        outcomes_seen++;
        chk("busy_low_at_pulse", busy, 0);
        chk("done_and_err_exclusive", int'(done & nack_err), 0);
        if (exp_out.size() == 0) begin
          chk("unexpected_outcome", int'(done), -1);
        end else begin
          o = exp_out.pop_front();
          chk("outcome_done", done, o.ok);
          chk("outcome_nack_err", nack_err, !o.ok);
          if (!o.ok) chk("fail_idx", fail_idx, o.idx);
        end
      end
      if (prev_done) chk("done_one_cycle", done, 0);
    end
    prev_done = done;
    prev_scl = scl_l;
    prev_sda = sda_l;
  end

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) nack_plan[i] = 3;
  endtask

  task automatic launch(input logic [TW-1:0] tbl, output int ntx, output int base);
    build_expect(tbl, ntx);
    base = outcomes_seen;
    seq_id++;
    @(negedge clk);
    wr_table = tbl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_seq(input int ntx, input int base);
    int waited = 0;
    while (outcomes_seen == base && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    if (outcomes_seen == base) chk("sequence_timeout", 0, 1);
    repeat (5) @(negedge clk);
    chk("bytes_left", exp_bytes.size(), 0);
    chk("start_count", txn_cnt, ntx);
    chk("busy_idle_after", busy, 0);
  endtask

  initial begin
    logic [TW-1:0] nominal;
    logic [TW-1:0] tbl;
    int ntx, base, waited;

    nominal = {16'h033C, 16'h0700, 16'h02A5, 16'h0600};
    clear_plan();
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nack_err", nack_err, 0);
    chk("rst_fail_idx", fail_idx, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal run.
    launch(nominal, ntx, base);
    finish_seq(ntx, base);

    // Transient NACK on the data byte of entry 1.
    clear_plan();
    nack_plan[1] = 2;
    launch(nominal, ntx, base);
    finish_seq(ntx, base);

    // Persistent NACK on the address byte of entry 2.
    clear_plan();
    nack_plan[2] = 0; nack_plan[3] = 0; nack_plan[4] = 0;
    launch(nominal, ntx, base);
    finish_seq(ntx, base);
    chk("persist_fail_idx_held", fail_idx, 2);

    // Start while busy plus table rewrite during entry 0.
    clear_plan();
    tbl = {$urandom, $urandom};
    launch(tbl, ntx, base);
    repeat (200) @(negedge clk);
    start = 1'b1;
    wr_table = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    wr_table = {$urandom, $urandom};
    chk("busy_ignores_start", busy, 1);
    finish_seq(ntx, base);

    // Reset during bit 4 of the register byte, then a full run.
    launch(nominal, ntx, base);
    waited = 0;
    while (!(in_txn && byte_idx == 1 && bitcnt == 4) && waited < 5000) begin
      @(posedge clk);
      waited++;
    end
    if (waited >= 5000) chk("reset_point_timeout", 0, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_scl_oe", scl_oe, 0);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    launch(nominal, ntx, base);
    finish_seq(ntx, base);

    // Randomised tables and NACK plans.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++)
        nack_plan[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 3;
      tbl = {$urandom, $urandom};
      launch(tbl, ntx, base);
      finish_seq(ntx, base);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/i2c_seq_writer.md
Name: i2c_seq_writer

Overview:
Parametrised I2C write sequencer that configures ROIC registers. It replaces the fixed 4-write gate-GPIO master.
- Runs entirely on the system clock; a quarter-period tick enable generates SCL, so no derived clock.
- On a start pulse, performs NUM_WRITES 3-byte transactions (slave address, register, data) from a latched table.
- Checks ACK per byte, retries on NACK, and inserts a programmable gap between transactions.
- Sits between the sensor-config controller and the open-drain I2C pads.

Parameters:
- CLK_DIV, 5: system clocks per SCL quarter-period (25 MHz / (4*5) = 1.25 MHz SCL); must be >= 2.
- SLAVE_ADDR, 7'h74: 7-bit slave address; R/W bit is always 0.
- NUM_WRITES, 4: number of table entries per sequence, 1..16.
- GAP_CYCLES, 50000: idle system clocks between transactions (2 ms at 25 MHz).
- MAX_RETRY, 2: re-attempts of a NACKed transaction before aborting.

Ports:
- s_clk_25mhz  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a sequence when idle
- wr_table  in  NUM_WRITES*16  entry k = bits [16k+15:16k] = {reg[7:0], data[7:0]}; entry 0 is sent first
- sda_in  in  1  synchronised SDA pad level
- scl_oe  out  1  1 = pull SCL low; 0 = release
- sda_oe  out  1  1 = pull SDA low; 0 = release
- busy  out  1  high from the cycle after an accepted start until done/error
- done  out  1  one-cycle pulse on successful completion
- nack_err  out  1  one-cycle pulse on abort after retries are exhausted
- fail_idx  out  4  index of the failing entry; held until the next start

Behaviour:
- Reset: scl_oe=0, sda_oe=0, busy=0, done=0, nack_err=0, fail_idx=0, state IDLE, all counters 0.
- Reset mid-transaction releases both lines on the next clock; no STOP is generated.
- Tick: a divider counts 0..CLK_DIV-1 and emits a one-cycle tick at wrap. The divider is held at 0 in IDLE.
- Phase counter q in 0..3 advances on each tick. Per data bit:
  - q0: SCL low, drive SDA = bit.
  - q1: SCL low.
  - q2: SCL released.
  - q3: SCL released.
- start is accepted only in IDLE. The table is latched into an internal register that cycle. start while busy is ignored, and wr_table changes during a run have no effect.
- States:
  - IDLE -> START on accepted start.
  - START: q0/q1 both lines released; q2 SDA low; q3 SCL low. -> BYTE, byte_sel=0.
  - BYTE: 8 bits MSB first. byte_sel 0 = {SLAVE_ADDR,1'b0}, 1 = reg, 2 = data. -> ACK.
  - ACK: SDA released all 4 quarters; sda_in sampled on the tick ending q2.
    - sample 0: byte_sel<2 -> BYTE (byte_sel+1); else -> STOP.
    - sample 1: -> STOP with nack flag set.
  - STOP: q0 SDA low, SCL low; q1 SCL released; q2 SDA released; q3 -> GAP.
  - GAP: count GAP_CYCLES system clocks, then:
    - nack flag clear: entry+1; if entry==NUM_WRITES-1 -> IDLE with done pulse; else -> START.
    - nack flag set, retry<MAX_RETRY: retry+1, same entry -> START.
    - nack flag set, retry==MAX_RETRY: -> IDLE with nack_err pulse, fail_idx=entry.
  - retry and nack flag clear on each successful entry.
- busy deasserts in the same cycle done or nack_err pulses.
- Counter widths: the GAP counter is sized with $clog2(GAP_CYCLES+1). GAP_CYCLES=0 means go directly to the next state.
- The pads are open-drain only: outputs never drive 1, only an enable.

Decomposition:
- Package i2c_pkg holds:
  - state enum typedef (IDLE, START, BYTE, ACK, STOP, GAP);
  - byte_sel localparams;
  - the entry-width constant (16).
- One sub-module, i2c_tick_gen: divider plus quarter-phase counter, with inputs en/rst and outputs tick and q[1:0].
- The sequencer FSM, shift register, and retry/gap logic live in the top module.

Test Plan:
- Nominal: NUM_WRITES=4, table {06:00, 02:A5, 07:00, 03:3C}, slave always ACKs.
  - Bus monitor decodes E8 06 00, E8 02 A5, E8 07 00, E8 03 3C.
  - Exactly 4 START/STOP pairs, with ≥GAP_CYCLES between each STOP and the next START.
  - done pulses once; busy low after.
- Transient NACK: slave NACKs the data byte of entry 1 once.
  - Entry 1 is retransmitted in full after a gap.
  - Sequence completes with done=1 and nack_err=0.
- Persistent NACK: slave NACKs the address byte of entry 2 always, MAX_RETRY=2.
  - Entry 2 is attempted 3 times, then nack_err pulses with fail_idx=2.
  - Entry 3 is never sent.
- Start while busy plus table change mid-run: pulse start again and rewrite wr_table during entry 0.
  - No restart occurs; the original table values appear on the bus.
- Reset mid-byte: assert rst during bit 4 of the reg byte.
  - Next cycle: scl_oe=0, sda_oe=0, busy=0.
  - A following start runs the full sequence correctly.
- Timing: CLK_DIV=5.
  - SCL high and low each measure 10 system clocks.
  - SDA never changes while SCL is released, except at START/STOP.
